alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Front-panel sequencer for the 4-bit two-operand ALU. Two debounced buttons drive an FSM that
//  edits operand A, operand B and the 2-bit op select, then runs the ALU.
//  After the ALU latency it captures C/Co and presents everything on the 4-digit hex display.
//  A sweep mode runs all four ops in turn, each held on the display for SWEEP_TICKS cycles.
//  Sits between the pbdebounce outputs and the ALU/DispNum instances in the board top.
// PARAMETERS
//  ALU_LAT      1           cycles from operand/op drive to result capture (>=1)
//  SWEEP_TICKS  25_000_000  cycles each sweep result is held on display (>=1)
// PORTS
//  clk        in   1   system clock; one clock domain, all state on posedge clk
//  rst        in   1   reset; synchronous, active-high
//  btn_next   in   1   debounced level: advance step
//  btn_inc    in   1   debounced level: increment field / start sweep
//  alu_c      in   4   ALU result
//  alu_co     in   1   ALU carry/borrow out
//  alu_a      out  4   operand A register
//  alu_b      out  4   operand B register
//  alu_s      out  2   op select to ALU
//  disp_hexs  out  16  {A, B, mid, C_q}; mid = {2'b00,op} in edit states, else {3'b000,co_q}
//  busy       out  1   high in S_EXEC, S_CAPT, S_SWEEP
//  state_o    out  3   current state encoding (debug LEDs)
// BEHAVIOUR
//  - Reset: A=B=op=0, c_q=0, co_q=0, sweep_idx=0, counters=0, state=S_EDIT_A, busy=0.
//    Both edge-detector prev regs reset to 1, so a button held through reset gives no pulse.
//  - Edge pulse = lvl & ~prev, combinational, one cycle wide. A held button gives exactly one pulse.
//  - Both pulses in the same cycle: btn_next wins, btn_inc is dropped.
//  - Pulses in S_EXEC/S_CAPT/S_SWEEP are ignored, never queued.
//  - S_EDIT_A: inc -> A=A+1 mod 16 (15 wraps to 0); next -> S_EDIT_B.
//  - S_EDIT_B: same for B; next -> S_EDIT_OP.
//  - S_EDIT_OP: inc -> op=op+1 mod 4; next -> S_EXEC, lat_cnt=0.
//  - S_EXEC: alu_s=op; lat_cnt increments each cycle; at lat_cnt==ALU_LAT-1 -> S_CAPT.
//  - S_CAPT: one cycle; c_q<=alu_c, co_q<=alu_co; -> S_SHOW.
//    Total latency from next-pulse edge to c_q valid: ALU_LAT+1 cycles.
//  - S_SHOW: next -> S_EDIT_A (A/B/op kept); inc -> S_SWEEP, sweep_idx=0, lat_cnt=0, hold_cnt=0.
//  - S_SWEEP: alu_s=sweep_idx. After ALU_LAT cycles, capture c_q/co_q.
//    Then hold SWEEP_TICKS cycles, sweep_idx++ and repeat.
//    After idx 3 hold completes: op<=3, -> S_SHOW.
//  - alu_a/alu_b are always the A/B registers. alu_s = op except in S_SWEEP.
//  - rst asserted in any state, including mid-EXEC or mid-SWEEP: full reset on that edge,
//    no partial capture.
//  - Counters sized $clog2(max(ALU_LAT,SWEEP_TICKS))+1. No arithmetic wider than 4 bits on data.
// STRUCTURE
//  - Package alu_seq_pkg: state localparams S_EDIT_A=0, S_EDIT_B=1, S_EDIT_OP=2, S_EXEC=3,
//    S_CAPT=4, S_SHOW=5, S_SWEEP=6. Op constants OP_0..OP_3.
//  - Sub-module btn_edge (lvl, prev reset to 1, pulse out), instantiated twice.
//  - FSM, counters and display mux stay in alu_seq_ctrl.
// TESTING (bench ALU model: op0 add, op1 sub, op2 and, op3 or, combinational;
//          ALU_LAT=1, SWEEP_TICKS=4)
//  1 Reset, 3 inc pulses, next, 5 inc, next, 0 inc, next -> A=3 B=5 op=0.
//    2 cycles later c_q=8 co_q=0; disp_hexs=16'h3508.
//  2 A=15 via 15 incs, 1 more inc -> A=0. op at 3 + inc -> op=0 (wrap both).
//  3 A=9, B=8, op=0, run -> c_q=1, co_q=1, disp_hexs=16'h9811; busy high exactly 2 cycles.
//  4 btn_next and btn_inc rise same cycle in S_EDIT_A -> state S_EDIT_B, A unchanged.
//    Button held 100 cycles -> one pulse.
//  5 From S_SHOW with A=6 B=3, inc -> sweep.
//    c_q sequence 9, 3, 2, 7, each held 4 cycles after ALU_LAT+capture; ends S_SHOW, op=3.
//  6 rst pulse mid-S_SWEEP (idx 2) -> next cycle state=S_EDIT_A, all outputs zero.
//    btn held across reset -> no pulse.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared state encoding and op-select constants for the ALU front-panel sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_seq_pkg;

    // Encoding is visible on the debug LEDs through state_o, so values are fixed.
    typedef enum logic [2:0] {
        S_EDIT_A  = 3'd0,
        S_EDIT_B  = 3'd1,
        S_EDIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_CAPT    = 3'd4,
        S_SHOW    = 3'd5,
        S_SWEEP   = 3'd6
    } state_t;

    localparam logic [1:0] OP_0 = 2'd0;
    localparam logic [1:0] OP_1 = 2'd1;
    localparam logic [1:0] OP_2 = 2'd2;
    localparam logic [1:0] OP_3 = 2'd3;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
// Latency: pulse is combinational from lvl, one cycle wide.
// Backpressure: none; a held level yields exactly one pulse.
//
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous active-high reset
//   lvl   in  1  debounced button level
//   pulse out 1  high for the first cycle lvl is seen high
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = lvl;
    end

    // prev resets high so a button already held through reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = lvl & ~prev_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Front-panel sequencer: edits A, B and op with two buttons, runs the ALU, shows the result.
// Latency: ALU_LAT+1 cycles from next-pulse edge to captured C/Co; sweep holds each op SWEEP_TICKS.
// Backpressure: button pulses arriving while busy (exec/capture/sweep) are dropped, not queued.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   btn_next, btn_inc   debounced button levels
//   alu_c, alu_co       ALU result and carry/borrow out
//   alu_a, alu_b, alu_s operand registers and op select driven to the ALU
//   disp_hexs           {A, B, mid, C}; mid = op in edit states, else carry
//   busy                high while the ALU is being run
//   state_o             current state encoding
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT     = 1,
    parameter int SWEEP_TICKS = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic [3:0]  alu_c,
    input  logic        alu_co,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_s,
    output logic [15:0] disp_hexs,
    output logic        busy,
    output logic [2:0]  state_o
);

    localparam int CNT_MAX = (ALU_LAT > SWEEP_TICKS) ? ALU_LAT : SWEEP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] LAT_END   = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SWEEP_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       c_q, c_d;
    logic             co_q, co_d;
    logic [1:0]       sweep_idx_q, sweep_idx_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             sw_hold_q, sw_hold_d;

    logic next_pls;
    logic inc_raw;
    logic inc_pls;

    btn_edge u_next_edge (
        .clk   (clk),
        .rst   (rst),
        .lvl   (btn_next),
        .pulse (next_pls)
    );

    btn_edge u_inc_edge (
        .clk   (clk),
        .rst   (rst),
        .lvl   (btn_inc),
        .pulse (inc_raw)
    );

    // next has priority: a simultaneous inc is dropped.
    assign inc_pls = inc_raw & ~next_pls;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        c_d         = c_q;
        co_d        = co_q;
        sweep_idx_d = sweep_idx_q;
        lat_cnt_d   = lat_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        sw_hold_d   = sw_hold_q;

        case (state_q)
            S_EDIT_A: begin
                if (next_pls)     state_d = S_EDIT_B;
                else if (inc_pls) a_d     = a_q + 4'd1;
            end
            S_EDIT_B: begin
                if (next_pls)     state_d = S_EDIT_OP;
                else if (inc_pls) b_d     = b_q + 4'd1;
            end
            S_EDIT_OP: begin
                if (next_pls) begin
                    state_d   = S_EXEC;
                    lat_cnt_d = '0;
                end else if (inc_pls) begin
                    op_d = op_q + 2'd1;
                end
            end
            S_EXEC: begin
                lat_cnt_d = lat_cnt_q + CNT_ONE;
                if (lat_cnt_q == LAT_LAST) state_d = S_CAPT;
            end
            S_CAPT: begin
                c_d     = alu_c;
                co_d    = alu_co;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (next_pls) begin
                    state_d = S_EDIT_A;
                end else if (inc_pls) begin
                    state_d     = S_SWEEP;
                    sweep_idx_d = 2'd0;
                    lat_cnt_d   = '0;
                    hold_cnt_d  = '0;
                    sw_hold_d   = 1'b0;
                end
            end
            S_SWEEP: begin
                // Per op: ALU_LAT settle cycles, one capture cycle (lat_cnt == ALU_LAT),
                // then SWEEP_TICKS hold cycles before moving to the next op.
                if (!sw_hold_q) begin
                    if (lat_cnt_q != LAT_END) begin
                        lat_cnt_d = lat_cnt_q + CNT_ONE;
                    end else begin
                        c_d        = alu_c;
                        co_d       = alu_co;
                        sw_hold_d  = 1'b1;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    sw_hold_d = 1'b0;
                    lat_cnt_d = '0;
                    if (sweep_idx_q == 2'd3) begin
                        op_d    = OP_3;
                        state_d = S_SHOW;
                    end else begin
                        sweep_idx_d = sweep_idx_q + 2'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_EDIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EDIT_A;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            op_q        <= OP_0;
            c_q         <= 4'd0;
            co_q        <= 1'b0;
            sweep_idx_q <= 2'd0;
            lat_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            sw_hold_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            c_q         <= c_d;
            co_q        <= co_d;
            sweep_idx_q <= sweep_idx_d;
            lat_cnt_q   <= lat_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            sw_hold_q   <= sw_hold_d;
        end
    end

    logic       edit_st;
    logic [3:0] mid;

    assign edit_st   = (state_q == S_EDIT_A) || (state_q == S_EDIT_B) || (state_q == S_EDIT_OP);
    assign mid       = edit_st ? {2'b00, op_q} : {3'b000, co_q};
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_s     = (state_q == S_SWEEP) ? sweep_idx_q : op_q;
    assign disp_hexs = {a_q, b_q, mid, c_q};
    assign busy      = (state_q == S_EXEC) || (state_q == S_CAPT) || (state_q == S_SWEEP);
    assign state_o   = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

    localparam int LAT   = 1;
    localparam int TICKS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_next;
    logic        btn_inc;
    logic [3:0]  alu_c;
    logic        alu_co;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_s;
    logic [15:0] disp_hexs;
    logic        busy;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.ALU_LAT(LAT), .SWEEP_TICKS(TICKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_next  (btn_next),
        .btn_inc   (btn_inc),
        .alu_c     (alu_c),
        .alu_co    (alu_co),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .disp_hexs (disp_hexs),
        .busy      (busy),
        .state_o   (state_o)
    );

    // Reference ALU: add, sub (co = borrow), and, or.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {(a < b), 4'(a - b)};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign {alu_co, alu_c} = alu_f(alu_a, alu_b, alu_s);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Idle/edit behaviour is tracked directly; a run is expanded into a per-cycle
    // timeline of expected (state, op select, capture) when it starts.
    typedef struct packed {
        logic [2:0] st;
        logic [1:0] s;
        logic       cap;
        logic       fin;
    } step_t;

    step_t      sched[$];
    step_t      cur;
    logic [2:0] m_st;
    logic [3:0] ma, mb, mc;
    logic [1:0] mop;
    logic       mco;
    logic       mp_next, mp_inc, pn, pi;

    task push(input logic [2:0] st, input logic [1:0] s, input logic cap, input logic fin);
        step_t e;
        e.st = st; e.s = s; e.cap = cap; e.fin = fin;
        sched.push_back(e);
    endtask

    always @(posedge clk) begin
        pn = btn_next & ~mp_next;
        pi = btn_inc & ~mp_inc & ~pn;
        mp_next = btn_next;
        mp_inc  = btn_inc;
        if (rst) begin
            m_st = 3'd0; ma = 4'd0; mb = 4'd0; mop = 2'd0; mc = 4'd0; mco = 1'b0;
            mp_next = 1'b1; mp_inc = 1'b1;
            sched.delete();
        end else if (sched.size() != 0) begin
            cur = sched.pop_front();
            if (cur.cap) {mco, mc} = alu_f(ma, mb, cur.s);
            if (cur.fin) mop = 2'd3;
            if (sched.size() == 0) m_st = 3'd5;
        end else begin
            case (m_st)
                3'd0: if (pn) m_st = 3'd1; else if (pi) ma = ma + 4'd1;
                3'd1: if (pn) m_st = 3'd2; else if (pi) mb = mb + 4'd1;
                3'd2: begin
                    if (pn) begin
                        for (int i = 0; i < LAT; i++) push(3'd3, mop, 1'b0, 1'b0);
                        push(3'd4, mop, 1'b1, 1'b0);
                    end else if (pi) begin
                        mop = mop + 2'd1;
                    end
                end
                3'd5: begin
                    if (pn) begin
                        m_st = 3'd0;
                    end else if (pi) begin
                        for (int k = 0; k < 4; k++) begin
                            for (int i = 0; i < LAT; i++) push(3'd6, 2'(k), 1'b0, 1'b0);
                            push(3'd6, 2'(k), 1'b1, 1'b0);
                            for (int t = 0; t < TICKS; t++)
                                push(3'd6, 2'(k), 1'b0, (k == 3) && (t == TICKS - 1));
                        end
                    end
                end
                default: m_st = 3'd0;
            endcase
        end
    end

    logic [2:0] e_st;
    logic [1:0] e_s;
    logic       e_busy;
    logic [3:0] e_mid;

    always @(negedge clk) begin
        if (chk_en) begin
            if (sched.size() != 0) begin
                e_st = sched[0].st; e_s = sched[0].s; e_busy = 1'b1;
            end else begin
                e_st = m_st; e_s = mop; e_busy = 1'b0;
            end
            e_mid = (e_st <= 3'd2) ? {2'b00, mop} : {3'b000, mco};
            check("state_o", 16'(state_o), 16'(e_st));
            check("alu_a", 16'(alu_a), 16'(ma));
            check("alu_b", 16'(alu_b), 16'(mb));
            check("alu_s", 16'(alu_s), 16'(e_s));
            check("busy", 16'(busy), 16'(e_busy));
            check("disp_hexs", disp_hexs, {ma, mb, e_mid, mc});
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input bit nxt, input int n);
        for (int i = 0; i < n; i++) begin
            if (nxt) btn_next = 1'b1; else btn_inc = 1'b1;
            @(negedge clk);
            btn_next = 1'b0;
            btn_inc  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", 16'(state_o), 16'(s));
    endtask

    int          bcnt;
    logic [3:0]  exp_c [4] = '{4'd9, 4'd3, 4'd2, 4'd7};

    initial begin
        rst = 1'b1; btn_next = 1'b0; btn_inc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_state", 16'(state_o), 16'd0);
        check("rst_disp", disp_hexs, 16'h0000);
        check("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: A=3 B=5 op=0 -> 8
        pulse(0, 3); pulse(1, 1); pulse(0, 5); pulse(1, 1); pulse(1, 1);
        wait_state(3'd5, 10);
        check("t1_disp", disp_hexs, 16'h3508);

        // 2: wrap A and op
        pulse(1, 1);
        pulse(0, 12);
        check("t2_a15", 16'(alu_a), 16'd15);
        pulse(0, 1);
        check("t2_a_wrap", 16'(alu_a), 16'd0);
        pulse(1, 2);
        pulse(0, 3);
        check("t2_op3", 16'(alu_s), 16'd3);
        pulse(0, 1);
        check("t2_op_wrap", 16'(alu_s), 16'd0);

        // 3: 9+8 -> c=1 co=1, busy for exactly 2 cycles
        pulse(1, 1);
        wait_state(3'd5, 10);
        pulse(1, 1); pulse(0, 9); pulse(1, 1); pulse(0, 3); pulse(1, 1);
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        check("t3_busy_cycles", 16'(bcnt), 16'd2);
        check("t3_disp", disp_hexs, 16'h9811);

        // 4: both buttons rise together, held 100 cycles
        pulse(1, 1);
        btn_next = 1'b1; btn_inc = 1'b1;
        repeat (100) @(negedge clk);
        check("t4_state", 16'(state_o), 16'd1);
        check("t4_a", 16'(alu_a), 16'd9);
        check("t4_b", 16'(alu_b), 16'd8);
        btn_next = 1'b0; btn_inc = 1'b0;
        @(negedge clk);

        // 5: A=6 B=3, sweep
        pulse(0, 11);
        check("t5_b", 16'(alu_b), 16'd3);
        pulse(1, 2);
        wait_state(3'd5, 10);
        pulse(1, 1); pulse(0, 13);
        check("t5_a", 16'(alu_a), 16'd6);
        pulse(1, 3);
        wait_state(3'd5, 10);
        btn_inc = 1'b1;
        @(negedge clk);
        btn_inc = 1'b0;
        for (int i = 0; i <= 24; i++) begin
            if (i % 6 == 2) check("t5_sweep_c", 16'(disp_hexs[3:0]), 16'(exp_c[i / 6]));
            if (i % 6 == 5) check("t5_sweep_hold", 16'(disp_hexs[3:0]), 16'(exp_c[i / 6]));
            if (i == 24) begin
                check("t5_end_state", 16'(state_o), 16'd5);
                check("t5_end_op", 16'(alu_s), 16'd3);
            end else begin
                @(negedge clk);
            end
        end

        // 6: reset mid-sweep with inc held across it
        btn_inc = 1'b1;
        @(negedge clk);
        repeat (13) @(negedge clk);
        check("t6_idx2", 16'(alu_s), 16'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_state", 16'(state_o), 16'd0);
        check("t6_outs", {alu_a, alu_b, 6'd0, alu_s}, 16'h0000);
        check("t6_disp", disp_hexs, 16'h0000);
        check("t6_busy", 16'(busy), 16'd0);
        repeat (5) @(negedge clk);
        check("t6_held_no_pulse", 16'(alu_a), 16'd0);
        btn_inc = 1'b0;
        @(negedge clk);
        pulse(0, 1);
        check("t6_inc_after", 16'(alu_a), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
